// File: rtl/vga_window_scanout.sv
// vga_window_scanout
//
// VGA scan-out engine. Generates horizontal and vertical timing for any mode.
// Scans a WIN_W x WIN_H window of an external double-buffered framebuffer RAM
// (synchronous read, RD_LAT cycles). The window is placed at (WIN_X, WIN_Y)
// inside the active area and each source pixel is replicated SCALE x SCALE.
//
// Ports
//   iCLK          pixel clock
//   iRST          synchronous active-high reset
//   iBUF_SEL      buffer to show from the next frame on (sampled at frame wrap)
//   iBORDER_RGB   {R,G,B} for active pixels outside the window
//   iFB_DATA      {R,G,B} RAM read data, valid RD_LAT cycles after oFB_RE
//   oFB_ADDR      {buffer, v*WIN_W+u} read address (held while oFB_RE = 0)
//   oFB_RE        read enable, high for in-window pixels only
//   oVGA_R/G/B    pixel colour
//   oVGA_H_SYNC   horizontal sync at SYNC_POL
//   oVGA_V_SYNC   vertical sync at SYNC_POL
//   oVGA_BLANK    1 = active video
//   oVGA_SYNC     tied to 0
//   oFRAME_START  one-cycle pulse when screen position (0,0) is on the outputs
//   oVBLANK       1 while the output line is outside the active lines
//
// Every output lags the timing counters by L = RD_LAT+2 cycles.
module vga_window_scanout #(
    parameter int H_SYNC_CYC   = 96,
    parameter int H_SYNC_BACK  = 48,
    parameter int H_SYNC_ACT   = 640,
    parameter int H_SYNC_FRONT = 16,
    parameter int V_SYNC_CYC   = 2,
    parameter int V_SYNC_BACK  = 33,
    parameter int V_SYNC_ACT   = 480,
    parameter int V_SYNC_FRONT = 10,
    parameter bit SYNC_POL     = 1'b0,
    parameter int WIN_W        = 256,
    parameter int WIN_H        = 256,
    parameter int WIN_X        = 192,
    parameter int WIN_Y        = 112,
    parameter int SCALE        = 1,
    parameter int COLOR_W      = 10,
    parameter int RD_LAT       = 1,
    localparam int PIX_AW      = $clog2(WIN_W * WIN_H),
    localparam int ADDR_W      = PIX_AW + 1
) (
    input  logic                   iCLK,
    input  logic                   iRST,
    input  logic                   iBUF_SEL,
    input  logic [3*COLOR_W-1:0]   iBORDER_RGB,
    input  logic [3*COLOR_W-1:0]   iFB_DATA,
    output logic [ADDR_W-1:0]      oFB_ADDR,
    output logic                   oFB_RE,
    output logic [COLOR_W-1:0]     oVGA_R,
    output logic [COLOR_W-1:0]     oVGA_G,
    output logic [COLOR_W-1:0]     oVGA_B,
    output logic                   oVGA_H_SYNC,
    output logic                   oVGA_V_SYNC,
    output logic                   oVGA_BLANK,
    output logic                   oVGA_SYNC,
    output logic                   oFRAME_START,
    output logic                   oVBLANK
);

    localparam int H_TOTAL = H_SYNC_CYC + H_SYNC_BACK + H_SYNC_ACT + H_SYNC_FRONT;
    localparam int V_TOTAL = V_SYNC_CYC + V_SYNC_BACK + V_SYNC_ACT + V_SYNC_FRONT;
    localparam int X_START = H_SYNC_CYC + H_SYNC_BACK;
    localparam int Y_START = V_SYNC_CYC + V_SYNC_BACK;
    // Window extents clipped to the active area.
    localparam int WX_END  = (WIN_X + WIN_W * SCALE > H_SYNC_ACT) ? H_SYNC_ACT : WIN_X + WIN_W * SCALE;
    localparam int WY_END  = (WIN_Y + WIN_H * SCALE > V_SYNC_ACT) ? V_SYNC_ACT : WIN_Y + WIN_H * SCALE;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int PIPE_D  = RD_LAT + 1;   // flag stages ahead of the output register
    localparam int REP_W   = 3;

    localparam logic [REP_W-1:0]  REP_LAST = REP_W'(SCALE - 1);
    localparam logic [PIX_AW-1:0] ROW_STEP = PIX_AW'(WIN_W);

    // Flag vector bit positions.
    localparam int F_HS  = 0;
    localparam int F_VS  = 1;
    localparam int F_ACT = 2;
    localparam int F_WIN = 3;
    localparam int F_FS  = 4;
    localparam int F_VB  = 5;

    // ---------------- stage 0: timing counters ----------------
    logic [HW-1:0] hCount;
    logic [VW-1:0] vCount;
    int            hPos;
    int            vPos;
    logic          hEnd;
    logic          vEnd;
    logic          winX;
    logic          winY;
    logic          inWin0;
    logic [5:0]    flags0;

    always_comb begin
        hPos   = 32'(hCount);
        vPos   = 32'(vCount);
        hEnd   = (hPos == H_TOTAL - 1);
        vEnd   = (vPos == V_TOTAL - 1);
        winX   = (hPos >= X_START + WIN_X) && (hPos < X_START + WX_END);
        winY   = (vPos >= Y_START + WIN_Y) && (vPos < Y_START + WY_END);
        inWin0 = winX && winY;
        flags0 = '0;
        flags0[F_HS]  = (hPos < H_SYNC_CYC);
        flags0[F_VS]  = (vPos < V_SYNC_CYC);
        flags0[F_ACT] = (hPos >= X_START) && (hPos < X_START + H_SYNC_ACT)
                     && (vPos >= Y_START) && (vPos < Y_START + V_SYNC_ACT);
        flags0[F_WIN] = inWin0;
        flags0[F_FS]  = (hPos == 0) && (vPos == 0);
        flags0[F_VB]  = !((vPos >= Y_START) && (vPos < Y_START + V_SYNC_ACT));
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            hCount <= '0;
            vCount <= '0;
        end else if (hEnd) begin
            hCount <= '0;
            vCount <= vEnd ? '0 : vCount + 1'b1;
        end else begin
            hCount <= hCount + 1'b1;
        end
    end

    // ---------------- stage 1: framebuffer address ----------------
    // u/uRep walk across the window line; vBase holds v*WIN_W and advances by
    // WIN_W every SCALE window lines, so no multiply or divide per pixel.
    logic [PIX_AW-1:0] uCount;
    logic [REP_W-1:0]  uRep;
    logic [PIX_AW-1:0] vBase;
    logic [REP_W-1:0]  vRep;
    logic              bufQ;
    logic [PIX_AW-1:0] pixAddr;
    logic [ADDR_W-1:0] fbAddrReg;
    logic              fbReReg;

    assign pixAddr = vBase + uCount;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            uCount    <= '0;
            uRep      <= '0;
            vBase     <= '0;
            vRep      <= '0;
            bufQ      <= 1'b0;
            fbAddrReg <= '0;
            fbReReg   <= 1'b0;
        end else begin
            fbReReg <= inWin0;
            if (inWin0) begin
                fbAddrReg <= {bufQ, pixAddr};
                if (uRep == REP_LAST) begin
                    uRep   <= '0;
                    uCount <= uCount + 1'b1;
                end else begin
                    uRep <= uRep + 1'b1;
                end
            end else begin
                uCount <= '0;
                uRep   <= '0;
            end
            // Buffer select changes only at the frame wrap so a frame never tears.
            if (hEnd && vEnd) begin
                vBase <= '0;
                vRep  <= '0;
                bufQ  <= iBUF_SEL;
            end else if (hEnd && winY) begin
                if (vRep == REP_LAST) begin
                    vRep  <= '0;
                    vBase <= vBase + ROW_STEP;
                end else begin
                    vRep <= vRep + 1'b1;
                end
            end
        end
    end

    assign oFB_ADDR = fbAddrReg;
    assign oFB_RE   = fbReReg;

    // ---------------- flag delay line, aligned with iFB_DATA ----------------
    genvar gi;
    for (gi = 0; gi < PIPE_D; gi++) begin : gStage
        logic [5:0] q;
        if (gi == 0) begin : gFirst
            always_ff @(posedge iCLK) begin
                if (iRST) q <= '0;
                else      q <= flags0;
            end
        end else begin : gNext
            always_ff @(posedge iCLK) begin
                if (iRST) q <= '0;
                else      q <= gStage[gi-1].q;
            end
        end
    end

    logic [5:0] flagsAligned;
    assign flagsAligned = gStage[PIPE_D-1].q;

    // ---------------- output register ----------------
    logic [3*COLOR_W-1:0] pixNext;
    logic [3*COLOR_W-1:0] rgbReg;
    logic                 hSyncReg;
    logic                 vSyncReg;
    logic                 blankReg;
    logic                 frameStartReg;
    logic                 vblankReg;

    always_comb begin
        pixNext = '0;
        if (flagsAligned[F_WIN])      pixNext = iFB_DATA;
        else if (flagsAligned[F_ACT]) pixNext = iBORDER_RGB;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            rgbReg        <= '0;
            hSyncReg      <= !SYNC_POL;
            vSyncReg      <= !SYNC_POL;
            blankReg      <= 1'b0;
            frameStartReg <= 1'b0;
            vblankReg     <= 1'b0;
        end else begin
            rgbReg        <= pixNext;
            hSyncReg      <= flagsAligned[F_HS] ? SYNC_POL : !SYNC_POL;
            vSyncReg      <= flagsAligned[F_VS] ? SYNC_POL : !SYNC_POL;
            blankReg      <= flagsAligned[F_ACT];
            frameStartReg <= flagsAligned[F_FS];
            vblankReg     <= flagsAligned[F_VB];
        end
    end

    assign oVGA_R       = rgbReg[3*COLOR_W-1 -: COLOR_W];
    assign oVGA_G       = rgbReg[2*COLOR_W-1 -: COLOR_W];
    assign oVGA_B       = rgbReg[COLOR_W-1:0];
    assign oVGA_H_SYNC  = hSyncReg;
    assign oVGA_V_SYNC  = vSyncReg;
    assign oVGA_BLANK   = blankReg;
    assign oVGA_SYNC    = 1'b0;
    assign oFRAME_START = frameStartReg;
    assign oVBLANK      = vblankReg;

endmodule

// File: tb/tb_vga_window_scanout.sv
module tb_vga_window_scanout;

    localparam int L1 = 3;      // RD_LAT 1
    localparam int L2 = 4;      // RD_LAT 2
    localparam int FRAME = 392; // 28 x 14 reduced mode

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        bufSel = 1'b0;
    logic [29:0] border = {10'd1000, 10'd500, 10'd250};

    int checkCount = 0;
    int passCount  = 0;

    // ---------------- reduced mode, RD_LAT 1 ----------------
    logic [29:0] fbData1 = '0;
    logic [4:0]  addr1;
    logic        re1, hs1, vs1, bl1, sy1, fs1, vb1;
    logic [9:0]  r1, g1, b1;

    vga_window_scanout #(
        .H_SYNC_CYC(4), .H_SYNC_BACK(4), .H_SYNC_ACT(16), .H_SYNC_FRONT(4),
        .V_SYNC_CYC(2), .V_SYNC_BACK(2), .V_SYNC_ACT(8), .V_SYNC_FRONT(2),
        .WIN_W(4), .WIN_H(4), .WIN_X(4), .WIN_Y(2), .SCALE(2), .RD_LAT(1)
    ) dut1 (
        .iCLK(clk), .iRST(rst), .iBUF_SEL(bufSel), .iBORDER_RGB(border),
        .iFB_DATA(fbData1), .oFB_ADDR(addr1), .oFB_RE(re1),
        .oVGA_R(r1), .oVGA_G(g1), .oVGA_B(b1),
        .oVGA_H_SYNC(hs1), .oVGA_V_SYNC(vs1), .oVGA_BLANK(bl1), .oVGA_SYNC(sy1),
        .oFRAME_START(fs1), .oVBLANK(vb1)
    );

    // RAM model: returns the pixel index on every channel.
    always @(posedge clk) if (re1) fbData1 <= {3{10'(addr1[3:0])}};

    // ---------------- reduced mode, RD_LAT 2 ----------------
    logic [29:0] fbData2 = '0;
    logic [29:0] ram2Stage = '0;
    logic [4:0]  addr2;
    logic        re2, hs2, vs2, bl2, sy2, fs2, vb2;
    logic [9:0]  r2, g2, b2;

    vga_window_scanout #(
        .H_SYNC_CYC(4), .H_SYNC_BACK(4), .H_SYNC_ACT(16), .H_SYNC_FRONT(4),
        .V_SYNC_CYC(2), .V_SYNC_BACK(2), .V_SYNC_ACT(8), .V_SYNC_FRONT(2),
        .WIN_W(4), .WIN_H(4), .WIN_X(4), .WIN_Y(2), .SCALE(2), .RD_LAT(2)
    ) dut2 (
        .iCLK(clk), .iRST(rst), .iBUF_SEL(bufSel), .iBORDER_RGB(border),
        .iFB_DATA(fbData2), .oFB_ADDR(addr2), .oFB_RE(re2),
        .oVGA_R(r2), .oVGA_G(g2), .oVGA_B(b2),
        .oVGA_H_SYNC(hs2), .oVGA_V_SYNC(vs2), .oVGA_BLANK(bl2), .oVGA_SYNC(sy2),
        .oFRAME_START(fs2), .oVBLANK(vb2)
    );

    always @(posedge clk) begin
        if (re2) ram2Stage <= {3{10'(addr2[3:0])}};
        fbData2 <= ram2Stage;
    end

    // ---------------- default 640x480 mode ----------------
    logic [29:0] fbDataD = '0;
    logic [16:0] addrD;
    logic        reD, hsD, vsD, blD, syD, fsD, vbD;
    logic [9:0]  rD, gD, bD;

    vga_window_scanout dutD (
        .iCLK(clk), .iRST(rst), .iBUF_SEL(bufSel), .iBORDER_RGB(border),
        .iFB_DATA(fbDataD), .oFB_ADDR(addrD), .oFB_RE(reD),
        .oVGA_R(rD), .oVGA_G(gD), .oVGA_B(bD),
        .oVGA_H_SYNC(hsD), .oVGA_V_SYNC(vsD), .oVGA_BLANK(blD), .oVGA_SYNC(syD),
        .oFRAME_START(fsD), .oVBLANK(vbD)
    );

    function automatic logic [29:0] expPix(int e);
        if (e < 0) return border;
        return {3{10'(e)}};
    endfunction

    // Holds reset for three edges; returns on the negedge where the counters
    // read (0,0), which the tests call n = 0.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int firstFs1 = -1;
        int firstFs2 = -1;
        logic hsAtL1 = 1'b1;
        do_reset();
        // run to counter position hc=10, vc=5 and reset there
        for (int n = 0; n < 5 * 28 + 10; n++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkCount++;
        if ({hs1, vs1, sy1, bl1, fs1, vb1, re1, addr1, r1, g1, b1} !== {2'b11, 10'b0, 30'b0})
            $display("FAIL reset_dut1: got %h expected %h",
                     {hs1, vs1, sy1, bl1, fs1, vb1, re1, addr1, r1, g1, b1}, {2'b11, 10'b0, 30'b0});
        else passCount++;
        @(negedge clk);
        @(negedge clk);
        checkCount++;
        if ({hs2, vs2, sy2, bl2, fs2, vb2, re2, r2, g2, b2} !== {2'b11, 5'b0, 30'b0})
            $display("FAIL reset_dut2: got %h expected %h",
                     {hs2, vs2, sy2, bl2, fs2, vb2, re2, r2, g2, b2}, {2'b11, 5'b0, 30'b0});
        else passCount++;
        checkCount++;
        if ({hsD, vsD, blD, reD} !== 4'b1100)
            $display("FAIL reset_default: got %b expected 1100", {hsD, vsD, blD, reD});
        else passCount++;
        rst = 1'b0;
        for (int n = 0; n < 8; n++) begin
            if (fs1 && firstFs1 < 0) firstFs1 = n;
            if (fs2 && firstFs2 < 0) firstFs2 = n;
            if (n == L1) hsAtL1 = hs1;
            @(negedge clk);
        end
        checkCount++;
        if (firstFs1 != L1) $display("FAIL first_frame_start_lat1: got %0d expected %0d", firstFs1, L1);
        else passCount++;
        checkCount++;
        if (firstFs2 != L2) $display("FAIL first_frame_start_lat2: got %0d expected %0d", firstFs2, L2);
        else passCount++;
        checkCount++;
        if (hsAtL1 !== 1'b0) $display("FAIL hsync_at_restart: got %b expected 0", hsAtL1);
        else passCount++;
    endtask

    task automatic test_sync_timing();
        int hsBad = 0;
        int vsLow = 0;
        int vsBad = 0;
        int fsCount = 0;
        int fsBad = 0;
        int lineBad = 0;
        int lineLow [28];
        for (int i = 0; i < 28; i++) lineLow[i] = 0;
        do_reset();
        for (int n = 0; n < L1 + 2 * FRAME; n++) begin
            if (n >= L1) begin
                int m = n - L1;
                if (!hs1) lineLow[m / 28]++;
                if ((!hs1) != ((m % 28) < 4)) hsBad++;
                if (m < FRAME && !vs1) vsLow++;
                if ((!vs1) != ((m % FRAME) < 56)) vsBad++;
                if (fs1) begin
                    fsCount++;
                    if (m % FRAME != 0) fsBad++;
                end
            end
            @(negedge clk);
        end
        for (int i = 0; i < 28; i++) if (lineLow[i] != 4) lineBad++;
        checkCount++;
        if (lineBad != 0) $display("FAIL hsync_low_per_line: got %0d bad lines expected 0", lineBad);
        else passCount++;
        checkCount++;
        if (hsBad != 0) $display("FAIL hsync_position: got %0d wrong cycles expected 0", hsBad);
        else passCount++;
        checkCount++;
        if (vsLow != 56) $display("FAIL vsync_low_cycles: got %0d expected 56", vsLow);
        else passCount++;
        checkCount++;
        if (vsBad != 0) $display("FAIL vsync_position: got %0d wrong cycles expected 0", vsBad);
        else passCount++;
        checkCount++;
        if (fsCount != 2 || fsBad != 0)
            $display("FAIL frame_start_period: got %0d pulses (%0d misplaced) expected 2 (0)", fsCount, fsBad);
        else passCount++;
    endtask

    logic [29:0] cap   [14][28];
    logic        blCap [14][28];
    logic        vbCap [14][28];

    task automatic test_window_pixels();
        int reads = 0;
        int rowVc [6] = '{4, 6, 7, 8, 10, 11};
        int expRow [6][16] = '{
            '{-1,-1,-1,-1, -1,-1,-1,-1, -1,-1,-1,-1, -1,-1,-1,-1},
            '{-1,-1,-1,-1,  0, 0, 1, 1,  2, 2, 3, 3, -1,-1,-1,-1},
            '{-1,-1,-1,-1,  0, 0, 1, 1,  2, 2, 3, 3, -1,-1,-1,-1},
            '{-1,-1,-1,-1,  4, 4, 5, 5,  6, 6, 7, 7, -1,-1,-1,-1},
            '{-1,-1,-1,-1,  8, 8, 9, 9, 10,10,11,11, -1,-1,-1,-1},
            '{-1,-1,-1,-1,  8, 8, 9, 9, 10,10,11,11, -1,-1,-1,-1}};
        int blankBad = 0;
        do_reset();
        for (int n = 0; n < L1 + FRAME; n++) begin
            if (n >= L1) begin
                int m = n - L1;
                cap[m / 28][m % 28]   = {r1, g1, b1};
                blCap[m / 28][m % 28] = bl1;
                vbCap[m / 28][m % 28] = vb1;
            end
            if (n < FRAME && re1) reads++;
            @(negedge clk);
        end
        for (int r = 0; r < 6; r++) begin
            int bad = 0;
            int firstX = -1;
            for (int x = 0; x < 16; x++) begin
                if (cap[rowVc[r]][8 + x] !== expPix(expRow[r][x])) begin
                    bad++;
                    if (firstX < 0) firstX = x;
                end
            end
            checkCount++;
            if (bad != 0)
                $display("FAIL row_vc%0d: %0d pixels wrong, x=%0d got %h expected %h", rowVc[r], bad,
                         firstX, cap[rowVc[r]][8 + firstX], expPix(expRow[r][firstX]));
            else passCount++;
        end
        for (int h = 0; h < 28; h++) begin
            logic inAct = (h >= 8 && h < 24);
            if (blCap[6][h] !== inAct) blankBad++;
            if (!inAct && cap[6][h] !== 30'd0) blankBad++;
        end
        checkCount++;
        if (blankBad != 0) $display("FAIL blank_line_vc6: got %0d wrong cycles expected 0", blankBad);
        else passCount++;
        checkCount++;
        if ({cap[12][12], blCap[12][12]} !== 31'd0)
            $display("FAIL clipped_row_vc12: got %h expected 0", {cap[12][12], blCap[12][12]});
        else passCount++;
        checkCount++;
        if ({vbCap[12][10], vbCap[6][0], vbCap[3][20]} !== 3'b101)
            $display("FAIL vblank_flag: got %b expected 101", {vbCap[12][10], vbCap[6][0], vbCap[3][20]});
        else passCount++;
        checkCount++;
        if (reads != 48) $display("FAIL reads_per_frame: got %0d expected 48", reads);
        else passCount++;
    endtask

    task automatic test_latency();
        int firstBl1 = -1, firstBl2 = -1, firstRe1 = -1, firstRe2 = -1;
        logic [29:0] p1 [4];
        logic [29:0] p2 [4];
        do_reset();
        for (int n = 0; n < 200; n++) begin
            if (bl1 && firstBl1 < 0) firstBl1 = n;
            if (bl2 && firstBl2 < 0) firstBl2 = n;
            if (re1 && firstRe1 < 0) firstRe1 = n;
            if (re2 && firstRe2 < 0) firstRe2 = n;
            // first window pixel counter cycle is hc=12, vc=6 -> 180
            if (n >= L1 + 179 && n < L1 + 183) p1[n - L1 - 179] = {r1, g1, b1};
            if (n >= L2 + 179 && n < L2 + 183) p2[n - L2 - 179] = {r2, g2, b2};
            @(negedge clk);
        end
        checkCount++;
        if (firstBl1 != 123) $display("FAIL blank_rise_lat1: got %0d expected 123", firstBl1);
        else passCount++;
        checkCount++;
        if (firstBl2 != 124) $display("FAIL blank_rise_lat2: got %0d expected 124", firstBl2);
        else passCount++;
        checkCount++;
        if (firstRe1 != 181 || firstRe2 != 181)
            $display("FAIL first_read: got %0d/%0d expected 181/181", firstRe1, firstRe2);
        else passCount++;
        checkCount++;
        if ({p1[0], p1[1], p1[3]} !== {border, expPix(0), expPix(1)})
            $display("FAIL first_pixel_lat1: got %h expected %h", {p1[0], p1[1], p1[3]},
                     {border, expPix(0), expPix(1)});
        else passCount++;
        checkCount++;
        if ({p2[0], p2[1], p2[3]} !== {border, expPix(0), expPix(1)})
            $display("FAIL first_pixel_lat2: got %h expected %h", {p2[0], p2[1], p2[3]},
                     {border, expPix(0), expPix(1)});
        else passCount++;
    endtask

    task automatic test_buffer_swap();
        int hi0 = 0, hi1 = 0, reads1 = 0;
        bufSel = 1'b0;
        do_reset();
        for (int n = 0; n < 2 * FRAME; n++) begin
            if (n == 200) bufSel = 1'b1;
            if (re1) begin
                if (n < FRAME) begin
                    if (addr1[4]) hi0++;
                end else begin
                    reads1++;
                    if (addr1[4]) hi1++;
                end
            end
            @(negedge clk);
        end
        checkCount++;
        if (hi0 != 0) $display("FAIL swap_mid_frame: got %0d buffer-1 reads expected 0", hi0);
        else passCount++;
        checkCount++;
        if (hi1 != 48 || reads1 != 48)
            $display("FAIL swap_next_frame: got %0d of %0d buffer-1 reads expected 48 of 48", hi1, reads1);
        else passCount++;
    endtask

    task automatic test_swap_edge();
        int hi [4] = '{0, 0, 0, 0};
        bufSel = 1'b0;
        do_reset();
        for (int n = 0; n < 4 * FRAME; n++) begin
            if (n == FRAME - 1) bufSel = 1'b1;   // during the wrap cycle: taken
            if (n == 2 * FRAME) bufSel = 1'b0;   // one cycle after a wrap: waits
            if (re1 && addr1[4]) hi[n / FRAME]++;
            @(negedge clk);
        end
        checkCount++;
        if ({hi[0], hi[1], hi[2], hi[3]} !== {32'd0, 32'd48, 32'd48, 32'd0})
            $display("FAIL swap_at_wrap: got %0d,%0d,%0d,%0d expected 0,48,48,0", hi[0], hi[1], hi[2], hi[3]);
        else passCount++;
        bufSel = 1'b0;
    endtask

    task automatic test_default_mode();
        int hsBad = 0, hsLow = 0, blCount = 0, vbCount = 0, fsCount = 0, reCount = 0;
        do_reset();
        for (int n = 0; n < L1 + 1600; n++) begin
            if (n >= L1) begin
                int m = n - L1;
                if (!hsD) hsLow++;
                if ((!hsD) != ((m % 800) < 96)) hsBad++;
                if (blD) blCount++;
                if (vbD) vbCount++;
                if (fsD) fsCount++;
            end
            if (reD) reCount++;
            @(negedge clk);
        end
        checkCount++;
        if (hsBad != 0 || hsLow != 192)
            $display("FAIL default_hsync: got %0d low (%0d misplaced) expected 192 (0)", hsLow, hsBad);
        else passCount++;
        checkCount++;
        if ({blCount, vbCount, fsCount, reCount} !== {32'd0, 32'd1600, 32'd1, 32'd0})
            $display("FAIL default_vblank_lines: got blank=%0d vblank=%0d fs=%0d re=%0d expected 0 1600 1 0",
                     blCount, vbCount, fsCount, reCount);
        else passCount++;
    endtask

    initial begin
        rst = 1'b1;
        repeat (4) @(negedge clk);
        test_reset();
        test_sync_timing();
        test_window_pixels();
        test_latency();
        test_buffer_swap();
        test_swap_edge();
        test_default_mode();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
